// File: rtl/sa_mux_sel_counter.sv
// Step counter and pass-control FSM for one systolic-array pass.
// Walks cnt 0..CNT_MAX, drains the array pipeline, then pulses done.
module sa_mux_sel_counter #(
  parameter int CNT_W        = 4,
  parameter int CNT_MAX      = 8,
  parameter int DRAIN_CYCLES = 2,
  parameter int DRN_W        = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_valid,
  output logic             first,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic [DRN_W-1:0] drn_inc_s;

  assign drn_inc_s = drn_q + DRN_W'(1);

  // Next-state and counter update logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        drn_d = '0;
        if (start) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (stall) begin
          state_d = S_RUN;
        end else if (cnt_q == CNT_LAST) begin
          // cnt stays at CNT_MAX through drain so the decoder never sees a wrap
          drn_d   = '0;
          state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (stall) begin
          state_d = S_DRAIN;
        end else if (drn_inc_s == DRN_LAST) begin
          drn_d   = drn_inc_s;
          state_d = S_DONE;
        end else begin
          drn_d = drn_inc_s;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        drn_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        drn_d   = '0;
      end
    endcase
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
    end
  end

  // cnt_valid follows stall within the cycle so a stalled step is never consumed
  assign cnt       = cnt_q;
  assign cnt_valid = (state_q == S_RUN) && !stall;
  assign first     = cnt_valid && (cnt_q == '0);
  assign last      = cnt_valid && (cnt_q == CNT_LAST);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_sa_mux_sel_counter.sv
// Directed self-checking bench for sa_mux_sel_counter (CNT_MAX=8, DRAIN_CYCLES=2).
module tb_sa_mux_sel_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic [3:0] cnt;
  logic       cnt_valid, first, last, busy, done;

  int checks = 0;
  int errors = 0;

  sa_mux_sel_counter #(
    .CNT_W(4), .CNT_MAX(8), .DRAIN_CYCLES(2), .DRN_W(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .cnt(cnt), .cnt_valid(cnt_valid), .first(first), .last(last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got {cnt,v,f,l,b,d}=%h_%b required %h_%b",
               tag, got[8:5], got[4:0], exp[8:5], exp[4:0]);
    end
  endtask

  // Apply inputs for the current cycle, check outputs, advance to the next cycle.
  task automatic cyc(input logic rs, input logic st, input logic sl,
                     input logic [3:0] ec, input logic ev, input logic ef,
                     input logic el, input logic eb, input logic ed, input string tag);
    reset = rs; start = st; stall = sl;
    #1;
    chk(tag, {cnt, cnt_valid, first, last, busy, done}, {ec, ev, ef, el, eb, ed});
    @(posedge clk);
    #1;
  endtask

  // Unstalled run cycles cnt=from..8 with start held at st.
  task automatic run_steps(input int from, input logic st, input string tag);
    for (int k = from; k <= 8; k++)
      cyc(1'b0, st, 1'b0, 4'(k), 1'b1, (k == 0), (k == 8), 1'b1, 1'b0, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    // Reset then idle
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    for (int i = 0; i < 2; i++)
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");

    // Nominal pass
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "nom_start");
    run_steps(0, 1'b0, "nom_run");
    for (int i = 0; i < 2; i++)
      cyc(1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "nom_drain");
    cyc(1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "nom_done");
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "nom_idle");

    // Stall mid-run at cnt=4 for 3 cycles
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "stl_start");
    for (int k = 0; k < 4; k++)
      cyc(1'b0, 1'b0, 1'b0, 4'(k), 1'b1, (k == 0), 1'b0, 1'b1, 1'b0, "stl_run");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "stl_hold");
    run_steps(4, 1'b0, "stl_resume");
    for (int i = 0; i < 2; i++)
      cyc(1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "stl_drain");
    cyc(1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "stl_done");
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "stl_idle");

    // Stall in first drain cycle for 2 cycles
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "dst_start");
    run_steps(0, 1'b0, "dst_run");
    for (int i = 0; i < 2; i++)
      cyc(1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "dst_stall");
    for (int i = 0; i < 2; i++)
      cyc(1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "dst_drain");
    cyc(1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "dst_done");
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "dst_idle");

    // start held high throughout: ignored mid-pass, back-to-back after done
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_start");
    run_steps(0, 1'b1, "b2b_run");
    for (int i = 0; i < 2; i++)
      cyc(1'b0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_drain");
    cyc(1'b0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "b2b_done");
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_idle");
    // second pass: first RUN cycle with stall high shows cnt=0 not valid
    cyc(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_stall0");
    for (int k = 0; k < 7; k++)
      cyc(1'b0, 1'b0, 1'b0, 4'(k), 1'b1, (k == 0), 1'b0, 1'b1, 1'b0, "b2b_run2");

    // Reset mid-run at cnt=7, then mid-pass at cnt=6 in a fresh pass
    cyc(1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "rst_at7");
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_idle");
    for (int k = 0; k < 6; k++)
      cyc(1'b0, 1'b0, 1'b0, 4'(k), 1'b1, (k == 0), 1'b0, 1'b1, 1'b0, "rst_run");
    cyc(1'b1, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "rst_at6");
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_nodone");

    // Reset during drain, then a full pass after reset
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rd_start");
    run_steps(0, 1'b0, "rd_run");
    cyc(1'b1, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "rd_drain_rst");
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rd_idle");
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "fin_start");
    run_steps(0, 1'b0, "fin_run");
    for (int i = 0; i < 2; i++)
      cyc(1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "fin_drain");
    cyc(1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "fin_done");
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "fin_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
